// File: rtl/c_bank_ctrl.sv
// c_bank_ctrl: sequencer for the DCO capacitor-bank matrix of c_sel cells.
// It captures a thermometer tuning target and moves the applied code toward it.
// It drives registered row/column/r_all selects into the bank.
// It pulses done once the bank has had time to settle.
//
// Configuration macro: C_BANK_SLEW_EN
//   defined   : code slews +/-1 unit cap per clk toward the target
//   undefined : code jumps to the target in a single edge
//
// Ports:
//   clk       in   1     clock, rising edge
//   rst       in   1     async reset, active high
//   en        in   1     block enable (0 forces IDLE, holds code/selects)
//   ld        in   1     load strobe, samples code_in
//   code_in   in   CW    target code, saturated to ROWS*COLS
//   row_full  out  ROWS  rows fully on (thermometer)
//   row_sel   out  ROWS  one-hot partially-filled row
//   col       out  COLS  columns on in the partial row (thermometer)
//   r_all     out  1     0 forces every cell on (bank full)
//   code      out  CW    currently applied code
//   busy      out  1     stepping or settling
//   done      out  1     one-cycle pulse when settled
module c_bank_ctrl #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned CW     = 7,
  parameter int unsigned SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ld,
  input  logic [CW-1:0]   code_in,
  output logic [ROWS-1:0] row_full,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col,
  output logic            r_all,
  output logic [CW-1:0]   code,
  output logic            busy,
  output logic            done
);

  localparam int unsigned MAX = ROWS * COLS;
  localparam int unsigned SW  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   target_q, target_d;
  logic [CW-1:0]   code_q, code_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] row_full_q, row_full_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_q, col_d;
  logic            r_all_q, r_all_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cin_sat;
  int unsigned     q_v, rem_v;

  // Next-state, next-code and settle counter
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    cin_sat  = (32'(code_in) > MAX) ? CW'(MAX) : code_in;

    if (!en) begin
      // Disabled: abandon any sequence, hold the applied code
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (ld) begin
      // Load/retarget wins over a concurrent step; code holds this edge
      target_d = cin_sat;
      cnt_d    = '0;
      state_d  = (cin_sat != code_q) ? S_STEP : S_SETTLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_STEP: begin
`ifdef C_BANK_SLEW_EN
          if (target_q > code_q)      code_d = code_q + CW'(1);
          else if (target_q < code_q) code_d = code_q - CW'(1);
`else
          code_d = target_q;
`endif
          if (code_d == target_q) state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SW'(SETTLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Bank decode from next code so selects always line up with code
  always_comb begin
    q_v        = 32'(code_d) / COLS;
    rem_v      = 32'(code_d) % COLS;
    row_full_d = '0;
    row_sel_d  = '0;
    col_d      = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_full_d[r] = (r < q_v);
      row_sel_d[r]  = (r == q_v) && (rem_v != 0);
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      col_d[c] = (c < rem_v);
    end
    r_all_d = (32'(code_d) != MAX);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      row_full_q <= '0;
      row_sel_q  <= '0;
      col_q      <= '0;
      r_all_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      row_full_q <= row_full_d;
      row_sel_q  <= row_sel_d;
      col_q      <= col_d;
      r_all_q    <= r_all_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign row_full = row_full_q;
  assign row_sel  = row_sel_q;
  assign col      = col_q;
  assign r_all    = r_all_q;
  assign code     = code_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_c_bank_ctrl.sv
// Directed self-checking bench for c_bank_ctrl (ROWS=COLS=8, CW=7, SETTLE=4).
// It adapts its expected stepping and latency to C_BANK_SLEW_EN.
module tb_c_bank_ctrl;

  localparam int SETTLE = 4;
`ifdef C_BANK_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ld;
  logic [6:0] code_in;
  logic [7:0] row_full;
  logic [7:0] row_sel;
  logic [7:0] col;
  logic       r_all;
  logic [6:0] code;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int m_code = 0;

  c_bank_ctrl #(.ROWS(8), .COLS(8), .CW(7), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .code_in(code_in),
    .row_full(row_full), .row_sel(row_sel), .col(col), .r_all(r_all),
    .code(code), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int step(input int c, input int t);
    if (!SLEW) return t;
    if (t > c) return c + 1;
    if (t < c) return c - 1;
    return c;
  endfunction

  function automatic int exp_lat(input int d);
    if (SLEW) return d + SETTLE + 1;
    return (d != 0) ? SETTLE + 2 : SETTLE + 1;
  endfunction

  function automatic logic [7:0] exp_rf(input int c);
    logic [8:0] t;
    t = (9'd1 << (c / 8)) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [7:0] exp_rs(input int c);
    logic [8:0] t;
    t = (c % 8 != 0) ? (9'd1 << (c / 8)) : 9'd0;
    return t[7:0];
  endfunction

  function automatic logic [7:0] exp_col(input int c);
    logic [8:0] t;
    t = (9'd1 << (c % 8)) - 9'd1;
    return t[7:0];
  endfunction

  task automatic check_dec(input string tag);
    check({tag, "_row_full"}, 32'(row_full), 32'(exp_rf(m_code)));
    check({tag, "_row_sel"},  32'(row_sel),  32'(exp_rs(m_code)));
    check({tag, "_col"},      32'(col),      32'(exp_col(m_code)));
    check({tag, "_r_all"},    32'(r_all),    32'(m_code != 64));
  endtask

  // Load a target, follow the code edge by edge and time the done pulse
  task automatic run_to(input string tag, input int tgt);
    int sat;
    int seen;
    int delta;
    sat   = (tgt > 64) ? 64 : tgt;
    delta = (sat > m_code) ? sat - m_code : m_code - sat;
    seen  = -1;
    ld = 1'b1;
    code_in = 7'(tgt);
    tick();
    ld = 1'b0;
    check({tag, "_ld_code_hold"}, 32'(code), 32'(m_code));
    check({tag, "_ld_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 200 && seen < 0; k++) begin
      tick();
      m_code = step(m_code, sat);
      if (code !== 7'(m_code)) check({tag, "_code_step"}, 32'(code), 32'(m_code));
      if (done === 1'b1) seen = k;
    end
    checks++;
    check({tag, "_done_latency"}, 32'(seen), 32'(exp_lat(delta)));
    check({tag, "_final_code"}, 32'(code), 32'(sat));
    check_dec(tag);
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int kk;
    rst = 1'b1;
    en = 1'b1;
    ld = 1'b0;
    code_in = '0;

    // 1. Reset values
    #12;
    check("rst_code", 32'(code), 32'd0);
    check("rst_r_all", 32'(r_all), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_row_full", 32'(row_full), 32'd0);
    check("rst_row_sel", 32'(row_sel), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // 2. 0 -> 10
    run_to("slew10", 10);
    check("slew10_rf_const", 32'(row_full), 32'h01);
    check("slew10_rs_const", 32'(row_sel), 32'h02);
    check("slew10_col_const", 32'(col), 32'h03);

    // 3. Saturation
    run_to("sat", 100);
    check("sat_code_const", 32'(code), 32'd64);
    check("sat_r_all_const", 32'(r_all), 32'd0);
    check("sat_rf_const", 32'(row_full), 32'hFF);
    check("sat_rs_const", 32'(row_sel), 32'h00);

    // 4. Retarget 0 -> 20, then 5 partway
    run_to("zero", 0);
    ld = 1'b1;
    code_in = 7'd20;
    tick();
    ld = 1'b0;
    kk = SLEW ? 12 : 1;
    for (int k = 0; k < kk; k++) begin
      tick();
      m_code = step(m_code, 20);
      if (done !== 1'b0) check("retgt_no_early_done", 32'(done), 32'd0);
    end
    check("retgt_mid_code", 32'(code), 32'(m_code));
    run_to("retgt5", 5);

    // 5. Reset mid-sequence
    ld = 1'b1;
    code_in = 7'd20;
    tick();
    ld = 1'b0;
    tick();
    if (SLEW) tick();
    #3 rst = 1'b1;
    #1;
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_r_all", 32'(r_all), 32'd1);
    check("midrst_row_full", 32'(row_full), 32'd0);
    #1 rst = 1'b0;
    m_code = 0;
    for (int k = 0; k < SETTLE + 4; k++) begin
      tick();
      if (done !== 1'b0 || code !== 7'd0) check("midrst_quiet", {24'd0, done, code}, 32'd0);
    end
    run_to("after_rst", 3);

    // 6. en=0 while stepping 30 -> 40
    run_to("to30", 30);
    ld = 1'b1;
    code_in = 7'd40;
    tick();
    check("en_ld_busy", 32'(busy), 32'd1);
    en = 1'b0;
    code_in = 7'd50;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (code !== 7'd30 || busy !== 1'b0 || done !== 1'b0)
        check("en0_frozen", {23'd0, busy, done, code}, 32'd30);
    end
    check("en0_code", 32'(code), 32'd30);
    check("en0_busy", 32'(busy), 32'd0);
    ld = 1'b0;
    en = 1'b1;
    tick();
    tick();
    check("en1_idle_code", 32'(code), 32'd30);
    check("en1_idle_busy", 32'(busy), 32'd0);
    run_to("to40", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
